control_unit: RTL and testbench

Multi-cycle sequencer for the core Datapath. It steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK. It drives the Datapath strobes (cu_decode, cu_execute, ld_*, branch, wr_en) from the decode status the Datapath returns (write_rd, update_flags, ig_ex, br_en). It also provides halt/resume at instruction boundaries and a retired-instruction counter.

---
 rtl/control_unit.sv | 136 +++++++++++++
 tb/tb_control_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the core datapath
// Every output is a register updated together with the state, so no input reaches an output combinationally.
module control_unit #(
  parameter int FETCH_WAIT = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             mem_store,
  input  logic             write_rd,
  input  logic             update_flags,
  input  logic             ig_ex,
  input  logic             br_en,
  output logic             cu_decode,
  output logic             cu_execute,
  output logic             wr_en,
  output logic             branch,
  output logic             ld_pc,
  output logic             ld_lr,
  output logic             ld_rd,
  output logic             ld_apsr,
  output logic             ld_sp,
  output logic             ld_ipsr,
  output logic             ld_primask,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam int FW_EFF = (FETCH_WAIT < 1) ? 1 : FETCH_WAIT;
  localparam int WCW    = $clog2(FW_EFF) + 1;
  localparam logic [WCW-1:0] FETCH_LAST = WCW'(FW_EFF - 1);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t         state_q;
  logic [WCW-1:0] wait_cnt;
  logic           halt_pending;
  logic           ig_l;
  logic           exec_ok;

  assign exec_ok    = ~ig_ex;
  assign state      = state_q;
  assign ld_sp      = 1'b0;
  assign ld_ipsr    = 1'b0;
  assign ld_primask = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET;
      wait_cnt     <= '0;
      halt_pending <= 1'b0;
      ig_l         <= 1'b0;
      retired      <= '0;
      cu_decode    <= 1'b0;
      cu_execute   <= 1'b0;
      ld_pc        <= 1'b0;
      branch       <= 1'b0;
      ld_lr        <= 1'b0;
      ld_rd        <= 1'b0;
      ld_apsr      <= 1'b0;
      wr_en        <= 1'b0;
      halted       <= 1'b0;
    end else begin
      cu_decode  <= 1'b0;
      cu_execute <= 1'b0;
      ld_pc      <= 1'b0;
      branch     <= 1'b0;
      ld_lr      <= 1'b0;
      ld_rd      <= 1'b0;
      ld_apsr    <= 1'b0;
      wr_en      <= 1'b0;
      halted     <= 1'b0;
      if (halt_req && state_q != S_HALT) halt_pending <= 1'b1;
      case (state_q)
        S_RESET: begin
          state_q  <= S_FETCH;
          wait_cnt <= '0;
        end
        S_FETCH: begin
          if (wait_cnt == FETCH_LAST) begin
            state_q   <= S_DECODE;
            cu_decode <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          state_q    <= S_EXECUTE;
          cu_execute <= 1'b1;
        end
        // Decode status is captured here and turned straight into the writeback strobes.
        S_EXECUTE: begin
          state_q <= S_WRITEBACK;
          ig_l    <= ig_ex;
          ld_pc   <= 1'b1;
          branch  <= br_en & exec_ok;
          ld_lr   <= br_en & exec_ok;
          ld_rd   <= write_rd & exec_ok;
          ld_apsr <= update_flags & exec_ok;
          wr_en   <= mem_store & exec_ok;
        end
        S_WRITEBACK: begin
          if (!ig_l) retired <= retired + 1'b1;
          if (halt_pending || halt_req) begin
            state_q      <= S_HALT;
            halted       <= 1'b1;
            halt_pending <= 1'b0;
          end else begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_HALT: begin
          if (resume && !halt_req) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
          end else begin
            halted <= 1'b1;
          end
        end
        default: state_q <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
// Two instances: defaults, and CNT_W=4 with FETCH_WAIT=0 (behaves as a one-cycle fetch).
module tb_control_unit;
  localparam int FW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, halt_req, resume, mem_store, write_rd, update_flags, ig_ex, br_en;

  logic a_cu_decode, a_cu_execute, a_wr_en, a_branch, a_ld_pc, a_ld_lr, a_ld_rd, a_ld_apsr;
  logic a_ld_sp, a_ld_ipsr, a_ld_primask, a_halted;
  logic [2:0] a_state;
  logic [31:0] a_retired;
  logic b_cu_decode, b_cu_execute, b_wr_en, b_branch, b_ld_pc, b_ld_lr, b_ld_rd, b_ld_apsr;
  logic b_ld_sp, b_ld_ipsr, b_ld_primask, b_halted;
  logic [2:0] b_state;
  logic [3:0] b_retired;

  control_unit dut_a (
    .clk(clk), .rst(rst), .halt_req(halt_req), .resume(resume), .mem_store(mem_store),
    .write_rd(write_rd), .update_flags(update_flags), .ig_ex(ig_ex), .br_en(br_en),
    .cu_decode(a_cu_decode), .cu_execute(a_cu_execute), .wr_en(a_wr_en), .branch(a_branch),
    .ld_pc(a_ld_pc), .ld_lr(a_ld_lr), .ld_rd(a_ld_rd), .ld_apsr(a_ld_apsr), .ld_sp(a_ld_sp),
    .ld_ipsr(a_ld_ipsr), .ld_primask(a_ld_primask), .halted(a_halted), .state(a_state),
    .retired(a_retired)
  );

  control_unit #(.FETCH_WAIT(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .halt_req(halt_req), .resume(resume), .mem_store(mem_store),
    .write_rd(write_rd), .update_flags(update_flags), .ig_ex(ig_ex), .br_en(br_en),
    .cu_decode(b_cu_decode), .cu_execute(b_cu_execute), .wr_en(b_wr_en), .branch(b_branch),
    .ld_pc(b_ld_pc), .ld_lr(b_ld_lr), .ld_rd(b_ld_rd), .ld_apsr(b_ld_apsr), .ld_sp(b_ld_sp),
    .ld_ipsr(b_ld_ipsr), .ld_primask(b_ld_primask), .halted(b_halted), .state(b_state),
    .retired(b_retired)
  );

  // {state, halted, cu_decode, cu_execute, ld_pc, branch, ld_lr, ld_rd, ld_apsr, wr_en, sp, ipsr, primask}
  wire [14:0] a_vec = {a_state, a_halted, a_cu_decode, a_cu_execute, a_ld_pc, a_branch, a_ld_lr,
                       a_ld_rd, a_ld_apsr, a_wr_en, a_ld_sp, a_ld_ipsr, a_ld_primask};
  wire [14:0] b_vec = {b_state, b_halted, b_cu_decode, b_cu_execute, b_ld_pc, b_branch, b_ld_lr,
                       b_ld_rd, b_ld_apsr, b_wr_en, b_ld_sp, b_ld_ipsr, b_ld_primask};

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0=reset, 1=running, 2=halted; phase counts cycles into the instruction.
  int     m_mode = 0;
  int     m_phase = 0;
  bit     m_pend = 0;
  bit     m_wr = 0, m_uf = 0, m_ig = 0, m_br = 0, m_st = 0;
  longint m_ret = 0;

  task automatic model_adv();
    if (rst) begin
      m_mode = 0; m_phase = 0; m_pend = 0; m_ret = 0;
      {m_wr, m_uf, m_ig, m_br, m_st} = '0;
      return;
    end
    if (halt_req && m_mode != 2) m_pend = 1;
    case (m_mode)
      0: begin m_mode = 1; m_phase = 0; end
      1: begin
        if (m_phase == FW + 1) begin
          {m_wr, m_uf, m_ig, m_br, m_st} = {write_rd, update_flags, ig_ex, br_en, mem_store};
          m_phase++;
        end else if (m_phase == FW + 2) begin
          if (!m_ig) m_ret++;
          if (m_pend) begin m_mode = 2; m_pend = 0; end
          else m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      default: if (resume && !halt_req) begin m_mode = 1; m_phase = 0; end
    endcase
  endtask

  function automatic logic [14:0] model_vec();
    logic [14:0] v;
    v = '0;
    if (m_mode == 2) begin
      v[14:12] = 3'd5;
      v[11] = 1'b1;
    end else if (m_mode == 1) begin
      v[14:12] = (m_phase < FW) ? 3'd1 : 3'(m_phase - FW + 2);
      v[10] = (m_phase == FW);
      v[9]  = (m_phase == FW + 1);
      if (m_phase == FW + 2) begin
        v[8] = 1'b1;
        v[7] = m_br & !m_ig;
        v[6] = m_br & !m_ig;
        v[5] = m_wr & !m_ig;
        v[4] = m_uf & !m_ig;
        v[3] = m_st & !m_ig;
      end
    end
    return v;
  endfunction

  task automatic check_vec(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_adv();
    @(negedge clk);
    check_vec("a_outputs", a_vec, model_vec());
    check_vec("b_outputs", b_vec, model_vec());
    check_int("a_retired", longint'(a_retired), m_ret & 64'hFFFF_FFFF);
    check_int("b_retired", longint'(b_retired), m_ret & 64'hF);
  endtask

  task automatic set_flags(input logic wr, input logic uf, input logic ig, input logic br, input logic st);
    write_rd = wr; update_flags = uf; ig_ex = ig; br_en = br; mem_store = st;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  typedef struct {
    logic       wr, uf, ig, br, st;
    logic [5:0] exp_wb;  // {ld_pc, branch, ld_lr, ld_rd, ld_apsr, wr_en}
    int         exp_inc;
  } vec_t;
  vec_t tbl[7];
  longint exp_ret;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b100110, 1};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b111000, 1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'b100000, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b100001, 1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'b111111, 1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b100000, 0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100000, 1};

    rst = 1'b1; halt_req = 1'b0; resume = 1'b0;
    set_flags(0, 0, 0, 0, 0);

    // Reset held two cycles, then one RESET cycle before FETCH
    cycle();
    cycle();
    check_vec("reset_all_zero", a_vec, 15'd0);
    check_int("reset_retired", longint'(a_retired), 0);
    rst = 1'b0;
    cycle();
    check_vec("first_fetch_state", 15'(a_state), 15'd1);

    exp_ret = 0;
    for (int i = 0; i < 7; i++) begin
      set_flags(tbl[i].wr, tbl[i].uf, tbl[i].ig, tbl[i].br, tbl[i].st);
      cycle();
      cycle();
      cycle();
      check_vec("wb_strobes", 15'(a_vec[8:3]), 15'(tbl[i].exp_wb));
      cycle();
      exp_ret += tbl[i].exp_inc;
      check_int("tbl_retired", longint'(a_retired), exp_ret);
    end

    // One-cycle halt_req during DECODE: instruction completes, then HALT
    set_flags(1, 0, 0, 0, 0);
    cycle();
    check_vec("halt_in_decode", 15'(a_state), 15'd2);
    halt_req = 1'b1;
    cycle();
    halt_req = 1'b0;
    cycle();
    check_vec("halt_wb_ld_rd", 15'({a_ld_pc, a_ld_rd}), 15'b11);
    cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_vec("halt_hold", a_vec, {3'd5, 1'b1, 11'd0});
    end
    resume = 1'b1; halt_req = 1'b1;
    cycle();
    check_vec("resume_blocked", 15'(a_state), 15'd5);
    halt_req = 1'b0;
    cycle();
    check_vec("resume_fetch", 15'(a_state), 15'd1);
    resume = 1'b0;

    // Counter wrap on the 4-bit instance
    do_reset();
    set_flags(0, 1, 0, 0, 0);
    for (int i = 0; i < 15 * (FW + 3); i++) cycle();
    check_int("wrap_before", longint'(b_retired), 15);
    for (int i = 0; i < FW + 3; i++) cycle();
    check_int("wrap_after", longint'(b_retired), 0);
    check_int("wrap_wide", longint'(a_retired), 16);

    // Reset during EXECUTE with retired=7
    do_reset();
    for (int i = 0; i < 7 * (FW + 3); i++) cycle();
    cycle();
    cycle();
    check_vec("in_execute", 15'(a_state), 15'd3);
    check_int("pre_rst_retired", longint'(a_retired), 7);
    rst = 1'b1;
    cycle();
    check_vec("rst_exec_outputs", a_vec, 15'd0);
    check_int("rst_exec_retired", longint'(a_retired), 0);
    rst = 1'b0;

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 79) == 0);
      halt_req = ($urandom_range(0, 15) == 0);
      resume   = ($urandom_range(0, 3) == 0);
      set_flags($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
